tensor_core_register_readout: RTL and testbench
===============================================

TENSOR_CORE_REGISTER_READOUT -- requirements
Module: tensor_core_register_readout

Interface
REQ-001 The block SHALL have parameter NUMBER_OF_REGISTERS, default 32, giving the number of 8-bit registers streamed; legal values are multiples of 16, and B = NUMBER_OF_REGISTERS/16.
REQ-002 The block SHALL have port clock_in, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset_in, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port start_in, input, 1 bit: request to begin a readout.
REQ-005 The block SHALL have port start_address_in, input, $clog2(NUMBER_OF_REGISTERS) bits: first flat register index to stream.
REQ-006 The block SHALL have port count_in, input, $clog2(NUMBER_OF_REGISTERS)+1 bits: number of bytes to stream, 0..NUMBER_OF_REGISTERS.
REQ-007 The block SHALL have port register_data_in, input, 8 bits x [B][4][4]: fully exposed register-file contents.
REQ-008 The block SHALL have port read_data_out, output, 8 bits: streamed byte.
REQ-009 The block SHALL have port read_address_out, output, $clog2(NUMBER_OF_REGISTERS) bits: flat index of read_data_out.
REQ-010 The block SHALL have port read_valid_out, output, 1 bit: read_data_out/read_address_out valid.
REQ-011 The block SHALL have port read_ready_in, input, 1 bit: consumer accepts the current byte.
REQ-012 The block SHALL have port busy_out, output, 1 bit: high whenever the state is not IDLE.
REQ-013 The block SHALL have port done_out, output, 1 bit: one-cycle pulse at readout completion.

Function
REQ-014 The block SHALL implement exactly three states: IDLE, STREAM, DONE.
REQ-015 In IDLE, start_in=1 at a rising edge SHALL capture all of register_data_in into an internal snapshot, load the address from start_address_in and the remaining count from count_in; the next state SHALL be STREAM if count_in!=0, else DONE.
REQ-016 Flat index a SHALL map to snapshot[a/16][(a%16)/4][a%4].
REQ-017 In STREAM, read_valid_out SHALL be 1 and read_data_out SHALL equal the snapshot byte at read_address_out; the first valid byte SHALL appear the cycle after start is accepted (latency 1).
REQ-018 A transfer SHALL occur at a rising edge where read_valid_out=1 and read_ready_in=1; otherwise read_data_out and read_address_out SHALL hold stable.
REQ-019 On each transfer the address SHALL increment modulo NUMBER_OF_REGISTERS (NUMBER_OF_REGISTERS-1 wraps to 0) and the remaining count SHALL decrement by 1.
REQ-020 The transfer that brings the remaining count to 0 SHALL move the state to DONE; read_valid_out SHALL be 0 in the following cycle.
REQ-021 In DONE, done_out SHALL be 1 for exactly one cycle, and the next state SHALL be IDLE unconditionally.
REQ-022 start_in SHALL be ignored in STREAM and DONE; a start_in held high through DONE SHALL be accepted in the first IDLE cycle.
REQ-023 Changes to register_data_in after start acceptance SHALL NOT affect streamed data.
REQ-024 read_valid_out SHALL be 0 in IDLE and DONE; read_data_out and read_address_out are don't-care when read_valid_out=0 but SHALL hold their last values.
REQ-025 count_in=NUMBER_OF_REGISTERS SHALL stream every register once, wrapping from any start address.

Reset
REQ-026 reset_in=1 at a rising edge SHALL force IDLE, read_valid_out=0, done_out=0, busy_out=0, read_data_out=0, read_address_out=0, remaining count=0 and all snapshot bytes=0, with priority over every other input, including in the middle of STREAM, where no done_out pulse SHALL follow.

Verification
REQ-027 The bench SHALL cover full readout: register_data_in[a]=a+8'h10, start_address 0, count 32, ready held 1 -> bytes 8'h10..8'h2F on 32 consecutive cycles starting 1 cycle after start, then done_out pulses once, then busy_out=0.
REQ-028 The bench SHALL cover wrap: start_address 30, count 4 -> addresses 30,31,0,1 with the matching bytes.
REQ-029 The bench SHALL cover back-pressure: ready toggled 1,0,0,1,... -> each byte is held while ready=0, no byte is skipped or duplicated, and the transfer total is exactly count.
REQ-030 The bench SHALL cover snapshot isolation: all inputs overwritten with 8'hFF one cycle after start, count 3 -> the original values are streamed.
REQ-031 The bench SHALL cover count zero: count_in=0 -> no valid byte, done_out=1 exactly one cycle after start, busy_out=1 for that one cycle.
REQ-032 The bench SHALL cover reset mid-stream: reset_in=1 after 5 of 16 transfers -> next cycle read_valid_out=0, busy_out=0, no done_out pulse, and a subsequent start streams correctly from its own start_address.

Source files
------------

// File: rtl/tensor_core_register_readout.sv
// Streams bytes from a snapshot of the tensor-core register file over a valid/ready port.
// state | meaning: IDLE waits for start; STREAM presents one byte per transfer; DONE pulses done_out once.
module tensor_core_register_readout #(
  parameter int NUMBER_OF_REGISTERS = 32
) (
  input  logic                                             clock_in,
  input  logic                                             reset_in,
  input  logic                                             start_in,
  input  logic [$clog2(NUMBER_OF_REGISTERS)-1:0]           start_address_in,
  input  logic [$clog2(NUMBER_OF_REGISTERS):0]             count_in,
  input  logic [NUMBER_OF_REGISTERS/16-1:0][3:0][3:0][7:0] register_data_in,
  output logic [7:0]                                       read_data_out,
  output logic [$clog2(NUMBER_OF_REGISTERS)-1:0]           read_address_out,
  output logic                                             read_valid_out,
  input  logic                                             read_ready_in,
  output logic                                             busy_out,
  output logic                                             done_out
);

  localparam int AW = $clog2(NUMBER_OF_REGISTERS);
  localparam int CW = AW + 1;
  localparam int FW = NUMBER_OF_REGISTERS * 8;

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  state_t          state_q, state_d;
  logic [FW-1:0]   snapshot_q;
  logic [FW-1:0]   register_flat;
  logic [CW-1:0]   remaining_q;
  logic [AW-1:0]   address_next;
  logic            start_accept;
  logic            transfer;
  logic            last_transfer;

  // Packed [b][row][col] ordering puts flat index a at bit offset a*8.
  assign register_flat = register_data_in;

  // Explicit wrap keeps non-power-of-two register counts correct.
  assign address_next = (read_address_out == AW'(NUMBER_OF_REGISTERS - 1)) ?
                        '0 : read_address_out + AW'(1);

  always_comb begin
    state_d        = state_q;
    start_accept   = 1'b0;
    transfer       = 1'b0;
    last_transfer  = 1'b0;
    read_valid_out = 1'b0;
    busy_out       = 1'b1;
    done_out       = 1'b0;
    case (state_q)
      IDLE: begin
        busy_out = 1'b0;
        if (start_in) begin
          start_accept = 1'b1;
          state_d      = (count_in != '0) ? STREAM : DONE;
        end
      end
      STREAM: begin
        read_valid_out = 1'b1;
        if (read_ready_in) begin
          transfer = 1'b1;
          if (remaining_q == CW'(1)) begin
            last_transfer = 1'b1;
            state_d       = DONE;
          end
        end
      end
      DONE: begin
        done_out = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      snapshot_q       <= '0;
      remaining_q      <= '0;
      read_address_out <= '0;
      read_data_out    <= '0;
    end else if (start_accept) begin
      snapshot_q       <= register_flat;
      remaining_q      <= count_in;
      read_address_out <= start_address_in;
      read_data_out    <= register_flat[{start_address_in, 3'b000} +: 8];
    end else if (transfer) begin
      remaining_q <= remaining_q - CW'(1);
      // The final byte stays on the outputs after the stream ends.
      if (!last_transfer) begin
        read_address_out <= address_next;
        read_data_out    <= snapshot_q[{address_next, 3'b000} +: 8];
      end
    end
  end

endmodule

// File: tb/tb_tensor_core_register_readout.sv
// Directed bench for tensor_core_register_readout (32 registers); inputs driven and outputs sampled on negedge.
module tb_tensor_core_register_readout;

  logic                         clock_in;
  logic                         reset_in;
  logic                         start_in;
  logic [4:0]                   start_address_in;
  logic [5:0]                   count_in;
  logic [1:0][3:0][3:0][7:0]    register_data_in;
  logic [7:0]                   read_data_out;
  logic [4:0]                   read_address_out;
  logic                         read_valid_out;
  logic                         read_ready_in;
  logic                         busy_out;
  logic                         done_out;

  int checks = 0;
  int passes = 0;

  tensor_core_register_readout #(.NUMBER_OF_REGISTERS(32)) dut (
    .clock_in         (clock_in),
    .reset_in         (reset_in),
    .start_in         (start_in),
    .start_address_in (start_address_in),
    .count_in         (count_in),
    .register_data_in (register_data_in),
    .read_data_out    (read_data_out),
    .read_address_out (read_address_out),
    .read_valid_out   (read_valid_out),
    .read_ready_in    (read_ready_in),
    .busy_out         (busy_out),
    .done_out         (done_out)
  );

  initial clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_byte(input logic [4:0] a, input logic [7:0] v);
    register_data_in[a[4]][a[3:2]][a[1:0]] = v;
  endtask

  task automatic fill_pattern();
    for (int i = 0; i < 32; i++) set_byte(5'(i), 8'(i + 16));
  endtask

  // Leaves the caller at the negedge of the first cycle after start acceptance.
  task automatic start_readout(input logic [4:0] a, input logic [5:0] c);
    start_in         = 1'b1;
    start_address_in = a;
    count_in         = c;
    @(negedge clock_in);
    start_in = 1'b0;
  endtask

  task automatic test_reset();
    reset_in = 1'b1;
    repeat (2) @(negedge clock_in);
    checks++;
    if ({read_valid_out, busy_out, done_out} !== 3'b000) begin
      $display("FAIL reset_ctrl: got valid/busy/done=%b, want 000", {read_valid_out, busy_out, done_out});
    end else passes++;
    checks++;
    if (read_data_out !== 8'h00 || read_address_out !== 5'd0) begin
      $display("FAIL reset_data: got data=%h addr=%0d, want data=00 addr=0", read_data_out, read_address_out);
    end else passes++;
    reset_in = 1'b0;
    @(negedge clock_in);
  endtask

  task automatic test_full_readout();
    fill_pattern();
    read_ready_in = 1'b1;
    start_readout(5'd0, 6'd32);
    for (int k = 0; k < 32; k++) begin
      checks++;
      if ({read_valid_out, read_address_out, read_data_out} !== {1'b1, 5'(k), 8'(k + 16)}) begin
        $display("FAIL full_byte%0d: got valid=%b addr=%0d data=%h, want valid=1 addr=%0d data=%h",
                 k, read_valid_out, read_address_out, read_data_out, k, 8'(k + 16));
      end else passes++;
      @(negedge clock_in);
    end
    checks++;
    if ({read_valid_out, done_out, busy_out} !== 3'b011) begin
      $display("FAIL full_done: got valid/done/busy=%b, want 011", {read_valid_out, done_out, busy_out});
    end else passes++;
    @(negedge clock_in);
    checks++;
    if ({read_valid_out, done_out, busy_out} !== 3'b000) begin
      $display("FAIL full_idle: got valid/done/busy=%b, want 000", {read_valid_out, done_out, busy_out});
    end else passes++;
  endtask

  task automatic test_wrap();
    logic [4:0] exp_a;
    start_readout(5'd30, 6'd4);
    for (int k = 0; k < 4; k++) begin
      exp_a = 5'd30 + 5'(k);
      checks++;
      if ({read_valid_out, read_address_out, read_data_out} !== {1'b1, exp_a, {3'b000, exp_a} + 8'h10}) begin
        $display("FAIL wrap_byte%0d: got valid=%b addr=%0d data=%h, want valid=1 addr=%0d data=%h",
                 k, read_valid_out, read_address_out, read_data_out, exp_a, {3'b000, exp_a} + 8'h10);
      end else passes++;
      @(negedge clock_in);
    end
    checks++;
    if ({read_valid_out, done_out} !== 2'b01) begin
      $display("FAIL wrap_done: got valid/done=%b, want 01", {read_valid_out, done_out});
    end else passes++;
    @(negedge clock_in);
  endtask

  task automatic test_back_pressure();
    logic [4:0] exp_a;
    int         xfers;
    exp_a = 5'd5;
    xfers = 0;
    start_readout(5'd5, 6'd6);
    for (int i = 0; i < 60; i++) begin
      if (!read_valid_out) break;
      checks++;
      if (read_address_out !== exp_a || read_data_out !== {3'b000, exp_a} + 8'h10) begin
        $display("FAIL bp_cycle%0d: got addr=%0d data=%h, want addr=%0d data=%h",
                 i, read_address_out, read_data_out, exp_a, {3'b000, exp_a} + 8'h10);
      end else passes++;
      read_ready_in = (i % 4 == 0) || (i % 4 == 3);
      if (read_ready_in) begin
        xfers++;
        exp_a = exp_a + 5'd1;
      end
      @(negedge clock_in);
    end
    checks++;
    if (xfers != 6 || {read_valid_out, done_out} !== 2'b01) begin
      $display("FAIL bp_total: got transfers=%0d valid/done=%b, want transfers=6 valid/done=01",
               xfers, {read_valid_out, done_out});
    end else passes++;
    read_ready_in = 1'b1;
    @(negedge clock_in);
  endtask

  task automatic test_snapshot();
    start_readout(5'd8, 6'd3);
    register_data_in = '1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({read_valid_out, read_address_out, read_data_out} !== {1'b1, 5'(8 + k), 8'(8'h18 + k)}) begin
        $display("FAIL snap_byte%0d: got valid=%b addr=%0d data=%h, want valid=1 addr=%0d data=%h",
                 k, read_valid_out, read_address_out, read_data_out, 8 + k, 8'(8'h18 + k));
      end else passes++;
      @(negedge clock_in);
    end
    checks++;
    if ({read_valid_out, done_out} !== 2'b01) begin
      $display("FAIL snap_done: got valid/done=%b, want 01", {read_valid_out, done_out});
    end else passes++;
    fill_pattern();
    @(negedge clock_in);
  endtask

  task automatic test_count_zero();
    start_readout(5'd3, 6'd0);
    checks++;
    if ({read_valid_out, done_out, busy_out} !== 3'b011) begin
      $display("FAIL zero_done: got valid/done/busy=%b, want 011", {read_valid_out, done_out, busy_out});
    end else passes++;
    @(negedge clock_in);
    checks++;
    if ({read_valid_out, done_out, busy_out} !== 3'b000) begin
      $display("FAIL zero_idle: got valid/done/busy=%b, want 000", {read_valid_out, done_out, busy_out});
    end else passes++;
  endtask

  // start_in held high: ignored in STREAM and DONE, accepted in the following IDLE cycle.
  task automatic test_back_to_back();
    start_in         = 1'b1;
    start_address_in = 5'd10;
    count_in         = 6'd1;
    @(negedge clock_in);
    checks++;
    if ({read_valid_out, read_address_out, read_data_out} !== {1'b1, 5'd10, 8'h1A}) begin
      $display("FAIL b2b_first: got valid=%b addr=%0d data=%h, want valid=1 addr=10 data=1a",
               read_valid_out, read_address_out, read_data_out);
    end else passes++;
    @(negedge clock_in);
    checks++;
    if ({read_valid_out, done_out} !== 2'b01) begin
      $display("FAIL b2b_done: got valid/done=%b, want 01", {read_valid_out, done_out});
    end else passes++;
    @(negedge clock_in);
    checks++;
    if ({read_valid_out, done_out, busy_out} !== 3'b000) begin
      $display("FAIL b2b_idle: got valid/done/busy=%b, want 000", {read_valid_out, done_out, busy_out});
    end else passes++;
    @(negedge clock_in);
    start_in = 1'b0;
    checks++;
    if ({read_valid_out, read_address_out, read_data_out} !== {1'b1, 5'd10, 8'h1A}) begin
      $display("FAIL b2b_second: got valid=%b addr=%0d data=%h, want valid=1 addr=10 data=1a",
               read_valid_out, read_address_out, read_data_out);
    end else passes++;
    repeat (2) @(negedge clock_in);
    checks++;
    if (busy_out !== 1'b0) begin
      $display("FAIL b2b_end: got busy=%b, want 0", busy_out);
    end else passes++;
  endtask

  task automatic test_reset_mid_stream();
    start_readout(5'd0, 6'd16);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (read_address_out !== 5'(k) || read_data_out !== 8'(k + 16)) begin
        $display("FAIL rst_pre%0d: got addr=%0d data=%h, want addr=%0d data=%h",
                 k, read_address_out, read_data_out, k, 8'(k + 16));
      end else passes++;
      @(negedge clock_in);
    end
    reset_in = 1'b1;
    @(negedge clock_in);
    checks++;
    if ({read_valid_out, busy_out, done_out, read_address_out, read_data_out} !== {3'b000, 5'd0, 8'h00}) begin
      $display("FAIL rst_mid: got valid/busy/done=%b addr=%0d data=%h, want 000 addr=0 data=00",
               {read_valid_out, busy_out, done_out}, read_address_out, read_data_out);
    end else passes++;
    reset_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock_in);
      checks++;
      if ({done_out, busy_out} !== 2'b00) begin
        $display("FAIL rst_nodone%0d: got done/busy=%b, want 00", k, {done_out, busy_out});
      end else passes++;
    end
    start_readout(5'd20, 6'd2);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({read_valid_out, read_address_out, read_data_out} !== {1'b1, 5'(20 + k), 8'(8'h24 + k)}) begin
        $display("FAIL rst_restart%0d: got valid=%b addr=%0d data=%h, want valid=1 addr=%0d data=%h",
                 k, read_valid_out, read_address_out, read_data_out, 20 + k, 8'(8'h24 + k));
      end else passes++;
      @(negedge clock_in);
    end
    checks++;
    if ({read_valid_out, done_out} !== 2'b01) begin
      $display("FAIL rst_restart_done: got valid/done=%b, want 01", {read_valid_out, done_out});
    end else passes++;
    @(negedge clock_in);
  endtask

  initial begin
    reset_in         = 1'b1;
    start_in         = 1'b0;
    start_address_in = '0;
    count_in         = '0;
    read_ready_in    = 1'b1;
    register_data_in = '0;
    @(negedge clock_in);
    test_reset();
    test_full_readout();
    test_wrap();
    test_back_pressure();
    test_snapshot();
    test_count_zero();
    test_back_to_back();
    test_reset_mid_stream();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
